// File: rtl/wallace_cpa_pipe.sv
// Final carry-propagate adder of the Wallace multiplier: resolves sum/carry rows in two
// valid/ready pipeline stages split at LO_W. Define WALLACE_CPA_OVF_EN to add the ovf_o port.
module wallace_cpa_pipe #(
    parameter int unsigned W    = 16,
    parameter int unsigned LO_W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] s_vec_i,
    input  logic [W-1:0] c_vec_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] p_o
`ifdef WALLACE_CPA_OVF_EN
    ,
    output logic         ovf_o
`endif
);
    localparam int unsigned HI_W = W - LO_W;

    logic [W-1:0]    c_shift;
    logic [LO_W:0]   lo_sum;
    logic [HI_W:0]   hi_sum;
    logic            b_free;
    logic            a_adv;
    logic            accept;

    logic            a_vld_q, a_vld_d;
    logic [LO_W-1:0] a_lo_q,  a_lo_d;
    logic            a_cy_q,  a_cy_d;
    logic [HI_W-1:0] a_hs_q,  a_hs_d;
    logic [HI_W-1:0] a_hc_q,  a_hc_d;
    logic            b_vld_q, b_vld_d;
    logic [W-1:0]    b_p_q,   b_p_d;

    // Carry row bit i carries weight 2^(i+1); its top bit falls outside the product.
    assign c_shift = {c_vec_i[W-2:0], 1'b0};
    assign lo_sum  = (LO_W+1)'(s_vec_i[LO_W-1:0]) + (LO_W+1)'(c_shift[LO_W-1:0]);
    assign hi_sum  = (HI_W+1)'(a_hs_q) + (HI_W+1)'(a_hc_q) + (HI_W+1)'(a_cy_q);

    assign b_free     = !b_vld_q || out_ready_i;
    assign a_adv      = a_vld_q && b_free;
    assign in_ready_o = rst_n && (!a_vld_q || b_free);
    assign accept     = in_valid_i && in_ready_o;

    // Next-state for both stages; A and B may both load on the same edge.
    always_comb begin
        a_vld_d = a_vld_q;
        a_lo_d  = a_lo_q;
        a_cy_d  = a_cy_q;
        a_hs_d  = a_hs_q;
        a_hc_d  = a_hc_q;
        b_vld_d = b_vld_q;
        b_p_d   = b_p_q;

        if (accept) begin
            a_vld_d = 1'b1;
            a_lo_d  = lo_sum[LO_W-1:0];
            a_cy_d  = lo_sum[LO_W];
            a_hs_d  = s_vec_i[W-1:LO_W];
            a_hc_d  = c_shift[W-1:LO_W];
        end else if (a_adv) begin
            a_vld_d = 1'b0;
        end

        if (a_adv) begin
            b_vld_d = 1'b1;
            b_p_d   = {hi_sum[HI_W-1:0], a_lo_q};
        end else if (out_ready_i) begin
            b_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_vld_q <= 1'b0;
            a_lo_q  <= '0;
            a_cy_q  <= 1'b0;
            a_hs_q  <= '0;
            a_hc_q  <= '0;
            b_vld_q <= 1'b0;
            b_p_q   <= '0;
        end else begin
            a_vld_q <= a_vld_d;
            a_lo_q  <= a_lo_d;
            a_cy_q  <= a_cy_d;
            a_hs_q  <= a_hs_d;
            a_hc_q  <= a_hc_d;
            b_vld_q <= b_vld_d;
            b_p_q   <= b_p_d;
        end
    end

    assign out_valid_o = b_vld_q;
    assign p_o         = b_p_q;

`ifdef WALLACE_CPA_OVF_EN
    // Overflow = dropped carry-row MSB or carry-out of the full-width add.
    logic a_cm_q, a_cm_d;
    logic b_ovf_q, b_ovf_d;

    always_comb begin
        a_cm_d  = a_cm_q;
        b_ovf_d = b_ovf_q;
        if (accept) begin
            a_cm_d = c_vec_i[W-1];
        end
        if (a_adv) begin
            b_ovf_d = a_cm_q | hi_sum[HI_W];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_cm_q  <= 1'b0;
            b_ovf_q <= 1'b0;
        end else begin
            a_cm_q  <= a_cm_d;
            b_ovf_q <= b_ovf_d;
        end
    end

    assign ovf_o = b_ovf_q;
`else
    logic [1:0] unused_ovf_bits;
    assign unused_ovf_bits = {c_vec_i[W-1], hi_sum[HI_W]};
`endif

endmodule

// File: tb/tb_wallace_cpa_pipe.sv
// Scoreboard bench for wallace_cpa_pipe (W=16, LO_W=8); covers ovf_o when WALLACE_CPA_OVF_EN is set.
module tb_wallace_cpa_pipe;
    localparam int unsigned W    = 16;
    localparam int unsigned LO_W = 8;

    logic         clk       = 1'b0;
    logic         rst_n     = 1'b0;
    logic         in_valid  = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] s_vec     = '0;
    logic [W-1:0] c_vec     = '0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] p;
`ifdef WALLACE_CPA_OVF_EN
    logic         ovf;
    localparam logic [W:0] OUT_MASK = {1'b1, {W{1'b1}}};
`else
    localparam logic [W:0] OUT_MASK = {1'b0, {W{1'b1}}};
`endif

    int checks   = 0;
    int failures = 0;
    int out_cnt  = 0;
    logic [W:0] sb[$];

    wallace_cpa_pipe #(.W(W), .LO_W(LO_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .s_vec_i     (s_vec),
        .c_vec_i     (c_vec),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .p_o         (p)
`ifdef WALLACE_CPA_OVF_EN
        ,
        .ovf_o       (ovf)
`endif
    );

    always #5 clk = ~clk;

    // Reference: {ovf, P} from a full-width add of S and the shifted carry row.
    function automatic logic [W:0] model(input logic [W-1:0] s, input logic [W-1:0] c);
        logic [W:0] sum;
        sum = {1'b0, s} + {1'b0, c[W-2:0], 1'b0};
        return {sum[W] | c[W-1], sum[W-1:0]};
    endfunction

    function automatic logic [W:0] cur_out();
`ifdef WALLACE_CPA_OVF_EN
        return {ovf, p};
`else
        return {1'b0, p};
`endif
    endfunction

    // Monitor: pushes on input handshake, pops/compares on output handshake, checks stall hold.
    initial begin
        logic       prev_stall;
        logic [W:0] prev_out;
        logic [W:0] exp;
        prev_stall = 1'b0;
        prev_out   = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    checks++;
                    if (out_valid !== 1'b1 || cur_out() !== prev_out) begin
                        failures++;
                        $display("FAIL stall_hold valid=%b out=%h required valid=1 out=%h",
                                 out_valid, cur_out(), prev_out);
                    end
                end
                if (out_valid && out_ready) begin
                    checks++;
                    if (sb.size() == 0) begin
                        failures++;
                        $display("FAIL scoreboard_extra out=%h with no result expected", cur_out());
                    end else begin
                        exp = sb.pop_front();
                        if ((cur_out() & OUT_MASK) !== (exp & OUT_MASK)) begin
                            failures++;
                            $display("FAIL scoreboard out=%h required=%h", cur_out() & OUT_MASK,
                                     exp & OUT_MASK);
                        end
                    end
                    out_cnt++;
                end
                if (in_valid && in_ready) sb.push_back(model(s_vec, c_vec));
                prev_stall = out_valid && !out_ready;
                prev_out   = cur_out();
            end
        end
    end

    // Presents one operand pair (called at posedge+1) and holds it until accepted.
    task automatic send(input logic [W-1:0] s, input logic [W-1:0] c);
        int   n;
        logic acc;
        n   = 0;
        acc = 1'b0;
        in_valid = 1'b1;
        s_vec    = s;
        c_vec    = c;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        checks++;
        if (!acc) begin
            failures++;
            $display("FAIL send_timeout accepted=%b required=1", acc);
        end
    endtask

    task automatic wait_results(input int target, input int budget, input string name);
        int n;
        n = 0;
        while (out_cnt < target && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (out_cnt < target) begin
            failures++;
            $display("FAIL %s results=%0d required=%0d", name, out_cnt, target);
        end
    endtask

    task automatic test_reset();
        #1;
        checks += 3;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b required=0", out_valid); end
        if (p !== '0)           begin failures++; $display("FAIL reset_p got=%h required=0", p); end
        if (in_ready !== 1'b0)  begin failures++; $display("FAIL reset_in_ready got=%b required=0", in_ready); end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        checks += 2;
        if (in_ready !== 1'b1)  begin failures++; $display("FAIL release_in_ready got=%b required=1", in_ready); end
        if (out_valid !== 1'b0) begin failures++; $display("FAIL release_valid got=%b required=0", out_valid); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_split_carry();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        s_vec     = 16'h00FF;
        c_vec     = 16'h0001;
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL split_ready got=%b required=1", in_ready); end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL split_early got=%b required=0", out_valid); end
        @(posedge clk);
        #1;
        checks += 2;
        if (out_valid !== 1'b1) begin failures++; $display("FAIL split_valid got=%b required=1", out_valid); end
        if (p !== 16'h0101)     begin failures++; $display("FAIL split_p got=%h required=0101", p); end
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL split_clear got=%b required=0", out_valid); end
    endtask

    task automatic test_overflow();
        out_ready = 1'b1;
        send(16'hFFFF, 16'h0001);
        @(posedge clk);
        #1;
        checks += 2;
        if (out_valid !== 1'b1) begin failures++; $display("FAIL ovf1_valid got=%b required=1", out_valid); end
        if (p !== 16'h0001)     begin failures++; $display("FAIL ovf1_p got=%h required=0001", p); end
`ifdef WALLACE_CPA_OVF_EN
        checks++;
        if (ovf !== 1'b1)       begin failures++; $display("FAIL ovf1_flag got=%b required=1", ovf); end
`endif
        send(16'h0000, 16'h8000);
        @(posedge clk);
        #1;
        checks += 2;
        if (out_valid !== 1'b1) begin failures++; $display("FAIL ovf2_valid got=%b required=1", out_valid); end
        if (p !== 16'h0000)     begin failures++; $display("FAIL ovf2_p got=%h required=0000", p); end
`ifdef WALLACE_CPA_OVF_EN
        checks++;
        if (ovf !== 1'b1)       begin failures++; $display("FAIL ovf2_flag got=%b required=1", ovf); end
`endif
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_pressure();
        logic [W-1:0] exp0;
        int           base;
        exp0      = model(16'h1111, 16'h0101) & {1'b0, {W{1'b1}}};
        out_ready = 1'b0;
        in_valid  = 1'b1;
        s_vec     = 16'h1111;
        c_vec     = 16'h0101;
        @(posedge clk);
        #1;
        s_vec = 16'hABCD;
        c_vec = 16'h4321;
        @(posedge clk);
        #1;
        s_vec = 16'h7FFF;
        c_vec = 16'h7FFF;
        for (int i = 0; i < 4; i++) begin
            checks += 3;
            if (in_ready !== 1'b0)  begin failures++; $display("FAIL bp_in_ready got=%b required=0", in_ready); end
            if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_valid got=%b required=1", out_valid); end
            if (p !== exp0)         begin failures++; $display("FAIL bp_p_held got=%h required=%h", p, exp0); end
            if (i < 3) begin
                @(posedge clk);
                #1;
            end
        end
        base      = out_cnt;
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_release_ready got=%b required=1", in_ready); end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_results(base + 3, 10, "bp_drain");
        repeat (2) @(posedge clk);
        #1;
        checks += 2;
        if (out_cnt != base + 3) begin failures++; $display("FAIL bp_count got=%0d required=%0d", out_cnt - base, 3); end
        if (sb.size() != 0)      begin failures++; $display("FAIL bp_leftover got=%0d required=0", sb.size()); end
    endtask

    task automatic test_streaming();
        int base;
        base      = out_cnt;
        out_ready = 1'b1;
        for (int i = 1; i <= 22; i++) begin
            in_valid = (i <= 20);
            s_vec    = W'($urandom);
            c_vec    = W'($urandom);
            @(posedge clk);
            #1;
            checks++;
            if (out_valid !== ((i >= 2) && (i <= 21))) begin
                failures++;
                $display("FAIL stream_valid edge=%0d got=%b required=%b", i, out_valid,
                         (i >= 2) && (i <= 21));
            end
        end
        in_valid = 1'b0;
        checks++;
        if (out_cnt != base + 20) begin failures++; $display("FAIL stream_count got=%0d required=20", out_cnt - base); end
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        s_vec     = 16'h5555;
        c_vec     = 16'h2222;
        @(posedge clk);
        #1;
        s_vec = 16'hFFFF;
        c_vec = 16'hFFFF;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1) begin failures++; $display("FAIL mid_prefill got=%b required=1", out_valid); end
        rst_n = 1'b0;
        #1;
        sb.delete();
        checks += 3;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_valid got=%b required=0", out_valid); end
        if (p !== '0)           begin failures++; $display("FAIL mid_p got=%h required=0", p); end
        if (in_ready !== 1'b0)  begin failures++; $display("FAIL mid_in_ready got=%b required=0", in_ready); end
`ifdef WALLACE_CPA_OVF_EN
        checks++;
        if (ovf !== 1'b0)       begin failures++; $display("FAIL mid_ovf got=%b required=0", ovf); end
`endif
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL mid_release_ready got=%b required=1", in_ready); end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(16'h1234, 16'h0000);
        @(posedge clk);
        #1;
        checks += 2;
        if (out_valid !== 1'b1) begin failures++; $display("FAIL mid_after_valid got=%b required=1", out_valid); end
        if (p !== 16'h1234)     begin failures++; $display("FAIL mid_after_p got=%h required=1234", p); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        localparam int N = 10000;
        int   sent;
        int   base;
        int   n;
        logic fire;
        sent     = 0;
        n        = 0;
        base     = out_cnt;
        in_valid = 1'b0;
        while (sent < N && n < 60000) begin
            if (!in_valid && $urandom_range(3) != 0) begin
                in_valid = 1'b1;
                s_vec    = W'($urandom);
                c_vec    = W'($urandom);
            end
            out_ready = ($urandom_range(3) != 0);
            @(negedge clk);
            fire = in_valid && in_ready;
            @(posedge clk);
            #1;
            n++;
            if (fire) begin
                sent++;
                in_valid = 1'b0;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (sent != N) begin failures++; $display("FAIL rand_sent got=%0d required=%0d", sent, N); end
        wait_results(base + N, 20, "rand_drain");
        repeat (2) @(posedge clk);
        #1;
        checks += 2;
        if (out_cnt != base + N) begin failures++; $display("FAIL rand_count got=%0d required=%0d", out_cnt - base, N); end
        if (sb.size() != 0)      begin failures++; $display("FAIL rand_leftover got=%0d required=0", sb.size()); end
    endtask

    initial begin
        test_reset();
        test_split_carry();
        test_overflow();
        test_back_pressure();
        test_streaming();
        test_reset_midstream();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
